park_token_ctrl: RTL and testbench
==================================

Name: park_token_ctrl

Overview:
- Parametrised parking-lot token controller; successor to the combinational exit decrypt block.
- Entry side: allocates the lowest free slot and issues an encrypted token (slot XOR pattern).
- Exit side: decrypts the token, validates it against an occupancy bitmap, then frees the slot. Consecutive bad exits trigger a lockout.
- Sits between the gate sensors/keypad logic and the lot display/barrier logic.

Parameters:
- SLOT_W, 3, width of slot index, token and pattern.
- NUM_SLOTS, 6, number of physical slots (2 ≤ NUM_SLOTS ≤ 2**SLOT_W).
- MAX_FAIL, 3, consecutive invalid exits before lockout (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pattern_we  in  1  load request for the cipher pattern.
- pattern_in  in  SLOT_W  new pattern value.
- pattern_err  out  1  one-cycle pulse: pattern load refused.
- entry_req  in  1  single-cycle entry request.
- entry_ack  out  1  one-cycle response pulse.
- entry_err  out  1  qualifies entry_ack: lot full, nothing allocated.
- entry_token  out  SLOT_W  issued token, valid with entry_ack.
- exit_req  in  1  single-cycle exit request.
- exit_token  in  SLOT_W  token presented at exit, sampled with exit_req.
- exit_ack  out  1  one-cycle response pulse.
- exit_err  out  1  qualifies exit_ack: rejected.
- exit_slot  out  SLOT_W  freed slot, valid with exit_ack and !exit_err.
- unlock  in  1  operator clears the lockout.
- locked  out  1  lockout active.
- full  out  1  no free slot.
- free_count  out  SLOT_W+1  number of free slots.
- occupancy  out  NUM_SLOTS  bit i = slot i occupied.

Behaviour:
- Reset (async, rst_n=0):
  - occupancy=0, pattern=0, fail count=0, state OPEN.
  - All pulses, tokens and exit_slot = 0.
  - free_count=NUM_SLOTS; full=0, locked=0.
  - A reset mid-operation discards any pending response.
- full and free_count are combinational from occupancy. All other outputs are registered.
- Latency: a request sampled at edge t produces its ack/err pulse, data and state update at edge t+1. Each pulse lasts exactly one cycle. Requests may arrive back-to-back every cycle.
- Entry handling:
  - Lot not full: allocate the lowest-index free slot s, set occupancy[s], entry_token = s ^ pattern, entry_err=0.
  - Lot full: entry_ack=1, entry_err=1, entry_token=0, no state change.
- Exit decode: d = exit_token ^ pattern.
  - Valid when d < NUM_SLOTS, occupancy[d]=1 and the state is OPEN.
  - Valid exit: clear occupancy[d], exit_slot=d, exit_err=0, fail count=0.
  - Invalid exit in OPEN: exit_err=1, exit_slot=0, fail count+1 (saturating). Reaching MAX_FAIL moves the FSM to LOCKED in the same update.
  - Any exit in LOCKED: exit_err=1, fail count unchanged.
- FSM, two states:
  - OPEN -> LOCKED on the MAX_FAIL-th consecutive invalid exit.
  - LOCKED -> OPEN on unlock=1, which also clears the fail count.
  - unlock in OPEN has no effect. locked=1 exactly in LOCKED.
  - Entries are unaffected by lockout.
- Simultaneous entry and exit in one cycle:
  - Both are processed.
  - Entry allocation uses occupancy before the exit, so the freed slot is not reusable in that cycle. A full lot still rejects the entry.
  - If the exit's decoded slot equals the slot being allocated, the exit is invalid (that slot was free).
- Pattern load:
  - pattern_we accepted only when occupancy==0; the new pattern applies from the next cycle.
  - Otherwise pattern_err pulses for one cycle and the pattern is unchanged.
  - pattern_we in the same cycle as entry_req while the lot is empty: load accepted, and the entry uses the old pattern.
- Widths: the fail counter is clog2(MAX_FAIL+1) bits. The free_count width covers NUM_SLOTS=2**SLOT_W.

Decomposition:
- Shared package park_pkg holds:
  - state enum {ST_OPEN, ST_LOCKED};
  - default SLOT_W/NUM_SLOTS constants;
  - function slot_xor(token, pattern), which replaces the standalone xor3bit.
- Natural sub-module: park_prio_alloc. It is a parametrised lowest-free-slot priority encoder over occupancy, giving an index plus a found flag.

Test Plan:
- Reset, then pattern_we with 3'b101 on an empty lot -> pattern_err=0. Two entries -> tokens 3'b101 (slot 0) then 3'b100 (slot 1), free_count=4.
- exit_token=3'b100 -> exit_ack=1, exit_err=0, exit_slot=1, occupancy=6'b000001, free_count=5.
- exit_token=3'b011 (d=6 ≥ NUM_SLOTS), then 3'b111 (slot 2 free), then 3'b110 (slot 3 free) -> three exit_err pulses, locked=1 after the third. A valid token 3'b101 while locked -> exit_err=1, slot 0 stays occupied. unlock -> locked=0, then token 3'b101 succeeds.
- Fill 6 slots -> full=1. A 7th entry -> entry_err=1, entry_token=0. Entry plus valid exit of slot 2 in the same cycle -> entry rejected, slot 2 freed, free_count=1.
- pattern_we=1 with pattern_in=3'b010 while occupied -> pattern_err pulse, and the next issued token still uses 3'b101.
- Assert rst_n=0 mid-stream with requests pending -> all outputs reset immediately (asynchronously), no ack after release, free_count=6.

Source files
------------

// File: rtl/park_pkg.sv
// park_pkg: shared state enum, default geometry and token cipher helper for the parking token controller
package park_pkg;
  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;
  localparam int DEF_SLOT_W = 3;
  localparam int DEF_NUM_SLOTS = 6;
  function automatic logic [31:0] slot_xor(input logic [31:0] token, input logic [31:0] pattern);
    return token ^ pattern;
  endfunction
endpackage

// File: rtl/park_prio_alloc.sv
// park_prio_alloc: lowest-free-slot priority encoder; occupancy in, idx/found out (found=0 when every slot is taken)
module park_prio_alloc #(
  parameter int SLOT_W = 3,
  parameter int NUM_SLOTS = 6
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    idx,
  output logic                 found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        idx = SLOT_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/park_token_ctrl.sv
// park_token_ctrl: slot allocator issuing XOR tokens, exit validation with lockout; ports: pattern load, entry/exit req+ack+err, unlock, locked/full/free_count/occupancy status
module park_token_ctrl
  import park_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int MAX_FAIL = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pattern_we,
  input  logic [SLOT_W-1:0]    pattern_in,
  output logic                 pattern_err,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic                 entry_err,
  output logic [SLOT_W-1:0]    entry_token,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_token,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [SLOT_W-1:0]    exit_slot,
  input  logic                 unlock,
  output logic                 locked,
  output logic                 full,
  output logic [SLOT_W:0]      free_count,
  output logic [NUM_SLOTS-1:0] occupancy
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);
  state_t                 state, state_n;
  logic [SLOT_W-1:0]      pattern, pattern_n, alloc_idx, d, entry_token_n, exit_slot_n;
  logic [NUM_SLOTS-1:0]   occ_n, dec, amask;
  logic [FW-1:0]          fail_cnt, fail_n, fail_inc;
  logic                   alloc_found, entry_ok, ok, bad;
  park_prio_alloc #(.SLOT_W(SLOT_W), .NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .occupancy(occupancy),
    .idx(alloc_idx),
    .found(alloc_found)
  );
  assign full = &occupancy;
  assign locked = state == ST_LOCKED;
  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) free_count = free_count + (SLOT_W + 1)'(!occupancy[i]);
  end
  // An out-of-range decoded slot shifts the one-hot mask off the end, so it can never hit an occupied bit.
  // The slot being allocated this cycle is free in the pre-update occupancy, so an exit naming it fails naturally.
  always_comb begin
    d = SLOT_W'(slot_xor(32'(exit_token), 32'(pattern)));
    dec = NUM_SLOTS'(1) << d;
    entry_ok = entry_req && alloc_found;
    amask = entry_ok ? NUM_SLOTS'(1) << alloc_idx : '0;
    ok = exit_req && state == ST_OPEN && |(dec & occupancy);
    bad = exit_req && state == ST_OPEN && !ok;
    fail_inc = fail_cnt == FMAX ? fail_cnt : fail_cnt + 1'b1;
    occ_n = (occupancy | amask) & ~(ok ? dec : '0);
    fail_n = (ok || (state == ST_LOCKED && unlock)) ? '0 : bad ? fail_inc : fail_cnt;
    state_n = state == ST_LOCKED ? (unlock ? ST_OPEN : ST_LOCKED) : (bad && fail_inc == FMAX ? ST_LOCKED : ST_OPEN);
    pattern_n = pattern_we && occupancy == '0 ? pattern_in : pattern;
    entry_token_n = entry_ok ? SLOT_W'(slot_xor(32'(alloc_idx), 32'(pattern))) : '0;
    exit_slot_n = ok ? d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OPEN;
      occupancy <= '0;
      pattern <= '0;
      fail_cnt <= '0;
      pattern_err <= 1'b0;
      entry_ack <= 1'b0;
      entry_err <= 1'b0;
      entry_token <= '0;
      exit_ack <= 1'b0;
      exit_err <= 1'b0;
      exit_slot <= '0;
    end else begin
      state <= state_n;
      occupancy <= occ_n;
      pattern <= pattern_n;
      fail_cnt <= fail_n;
      pattern_err <= pattern_we && occupancy != '0;
      entry_ack <= entry_req;
      entry_err <= entry_req && !alloc_found;
      entry_token <= entry_token_n;
      exit_ack <= exit_req;
      exit_err <= exit_req && !ok;
      exit_slot <= exit_slot_n;
    end
  end
endmodule

// File: tb/tb_park_token_ctrl.sv
// tb_park_token_ctrl: directed scoreboard bench for park_token_ctrl with SLOT_W=3, NUM_SLOTS=6, MAX_FAIL=3
module tb_park_token_ctrl;
  typedef struct packed {
    logic       e_ack;
    logic       e_err;
    logic [2:0] e_tok;
    logic       x_ack;
    logic       x_err;
    logic [2:0] x_slot;
    logic       p_err;
    logic       lk;
    logic       full;
    logic [3:0] fc;
    logic [5:0] occ;
  } obs_t;
  logic       clk, rst_n, pattern_we, pattern_err, entry_req, entry_ack, entry_err;
  logic       exit_req, exit_ack, exit_err, unlock, locked, full;
  logic [2:0] pattern_in, entry_token, exit_token, exit_slot;
  logic [3:0] free_count;
  logic [5:0] occupancy;
  obs_t       sb[$];
  int         passed = 0;
  int         total = 0;
  park_token_ctrl #(.SLOT_W(3), .NUM_SLOTS(6), .MAX_FAIL(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .pattern_we(pattern_we), .pattern_in(pattern_in), .pattern_err(pattern_err),
    .entry_req(entry_req), .entry_ack(entry_ack), .entry_err(entry_err), .entry_token(entry_token),
    .exit_req(exit_req), .exit_token(exit_token), .exit_ack(exit_ack), .exit_err(exit_err), .exit_slot(exit_slot),
    .unlock(unlock), .locked(locked), .full(full), .free_count(free_count), .occupancy(occupancy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic obs_t ex(input logic ea, input logic ee, input logic [2:0] et, input logic xa, input logic xe,
                              input logic [2:0] xs, input logic pe, input logic lk, input logic [5:0] occ);
    obs_t r;
    r.e_ack = ea; r.e_err = ee; r.e_tok = et;
    r.x_ack = xa; r.x_err = xe; r.x_slot = xs;
    r.p_err = pe; r.lk = lk; r.occ = occ;
    r.full = &occ;
    r.fc = 4'd6 - 4'($countones(occ));
    return r;
  endfunction
  function automatic obs_t observe();
    return {entry_ack, entry_err, entry_token, exit_ack, exit_err, exit_slot, pattern_err, locked, full, free_count, occupancy};
  endfunction
  task automatic check(input string tag);
    obs_t o, e;
    o = observe();
    e = sb.pop_front();
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, o, e);
  endtask
  task automatic step(input string tag, input logic er, input logic xr, input logic [2:0] xt,
                      input logic pw, input logic [2:0] pi, input logic ul, input obs_t e);
    @(negedge clk);
    entry_req = er; exit_req = xr; exit_token = xt;
    pattern_we = pw; pattern_in = pi; unlock = ul;
    sb.push_back(e);
    @(posedge clk);
    #1;
    {entry_req, exit_req, pattern_we, unlock} = '0;
    check(tag);
  endtask
  initial begin
    rst_n = 1'b0;
    {entry_req, exit_req, pattern_we, unlock} = '0;
    exit_token = '0; pattern_in = '0;
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 6'h00));
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    step("pat_load",      0, 0, 3'b000, 1, 3'b101, 0, ex(0, 0, 0,      0, 0, 0,      0, 0, 6'h00));
    step("entry_slot0",   1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b101, 0, 0, 0,      0, 0, 6'h01));
    step("entry_slot1",   1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b100, 0, 0, 0,      0, 0, 6'h03));
    step("exit_slot1",    0, 1, 3'b100, 0, 3'b000, 0, ex(0, 0, 0,      1, 0, 3'd1,   0, 0, 6'h01));
    step("exit_range",    0, 1, 3'b011, 0, 3'b000, 0, ex(0, 0, 0,      1, 1, 0,      0, 0, 6'h01));
    step("exit_free2",    0, 1, 3'b111, 0, 3'b000, 0, ex(0, 0, 0,      1, 1, 0,      0, 0, 6'h01));
    step("exit_lock",     0, 1, 3'b110, 0, 3'b000, 0, ex(0, 0, 0,      1, 1, 0,      0, 1, 6'h01));
    step("exit_locked",   0, 1, 3'b101, 0, 3'b000, 0, ex(0, 0, 0,      1, 1, 0,      0, 1, 6'h01));
    step("unlock",        0, 0, 3'b000, 0, 3'b000, 1, ex(0, 0, 0,      0, 0, 0,      0, 0, 6'h01));
    step("exit_slot0",    0, 1, 3'b101, 0, 3'b000, 0, ex(0, 0, 0,      1, 0, 3'd0,   0, 0, 6'h00));
    step("fill0",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b101, 0, 0, 0,      0, 0, 6'h01));
    step("fill1",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b100, 0, 0, 0,      0, 0, 6'h03));
    step("fill2",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b111, 0, 0, 0,      0, 0, 6'h07));
    step("fill3",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b110, 0, 0, 0,      0, 0, 6'h0f));
    step("fill4",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b001, 0, 0, 0,      0, 0, 6'h1f));
    step("fill5",         1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b000, 0, 0, 0,      0, 0, 6'h3f));
    step("entry_full",    1, 0, 3'b000, 0, 3'b000, 0, ex(1, 1, 0,      0, 0, 0,      0, 0, 6'h3f));
    step("full_ent_exit", 1, 1, 3'b111, 0, 3'b000, 0, ex(1, 1, 0,      1, 0, 3'd2,   0, 0, 6'h3b));
    step("pat_refused",   0, 0, 3'b000, 1, 3'b010, 0, ex(0, 0, 0,      0, 0, 0,      1, 0, 6'h3b));
    step("alloc_vs_exit", 1, 1, 3'b111, 0, 3'b000, 0, ex(1, 0, 3'b111, 1, 1, 0,      0, 0, 6'h3f));
    @(negedge clk);
    entry_req = 1'b1; exit_req = 1'b1; exit_token = 3'b101;
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 6'h00));
    check("async_reset");
    @(posedge clk);
    @(negedge clk);
    {entry_req, exit_req} = '0;
    rst_n = 1'b1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 6'h00));
    @(posedge clk);
    #1;
    check("no_ack_after_reset");
    step("entry_post_rst", 1, 0, 3'b000, 0, 3'b000, 0, ex(1, 0, 3'b000, 0, 0, 0,    0, 0, 6'h01));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
